cheri_clr_regs_seq: RTL and testbench

Sequencer that drives the capability-clear side of the integer register file's commit write port. It accepts one clear-registers request (32-bit register mask) from the CHERI execution path. It splits the request into per-quarter (8-register) clear writes, one per granted cycle on a shared commit port, then signals completion with the request's transaction ID. It sits between the CHERI functional unit and the commit-port mux in front of the register file.

---
 rtl/cheri_clr_regs_seq.sv | 193 +++++++++++++++++++
 tb/tb_cheri_clr_regs_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheri_clr_regs_seq.sv
// cheri_clr_regs_seq
// Turns one CHERI clear-registers request (32-bit register mask) into a
// sequence of per-quarter clear writes on the shared commit port of the
// integer register file, then reports completion with the request's
// scoreboard transaction ID.
//
// All outputs are decoded from registered state only, so there is no
// combinational path from the req_* inputs to the clr_* outputs.

module cheri_clr_regs_seq #(
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter bit          SKIP_EMPTY    = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_mask_i,
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,

    output logic                     clr_we_o,
    output logic                     clr_o,
    output logic [4:0]               clr_waddr_o,
    output logic [63:0]              clr_wdata_o,
    output logic [7:0]               clr_mask_o,
    output logic [1:0]               clr_quarter_o,
    input  logic                     clr_gnt_i,

    output logic                     done_valid_o,
    output logic [TRANS_ID_BITS-1:0] done_trans_id_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // Mask helpers
    // ------------------------------------------------------------------

    // Lowest quarter holding a non-zero mask byte; 3 when the mask is empty
    // (the result is only consumed while a quarter is still pending).
    function automatic logic [1:0] lowest_quarter(input logic [31:0] m);
        logic [1:0] res;
        res = 2'd3;
        for (int q = 3; q >= 0; q--) begin
            res = (m[q*8 +: 8] != 8'h00) ? 2'(q) : res;
        end
        return res;
    endfunction

    // Mask byte belonging to quarter q.
    function automatic logic [7:0] mask_byte(input logic [31:0] m,
                                             input logic [1:0]  q);
        return m[{q, 3'b000} +: 8];
    endfunction

    // Mask with the byte of quarter q forced to zero.
    function automatic logic [31:0] clear_byte(input logic [31:0] m,
                                               input logic [1:0]  q);
        return m & ~(32'h0000_00FF << {q, 3'b000});
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                   state_q,    state_d;
    logic [31:0]              rem_mask_q, rem_mask_d;
    logic [1:0]               cnt_q,      cnt_d;
    logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;

    logic [1:0]               cur_q_s;
    logic                     last_s;
    logic                     run_s;

    // Current quarter and whether granting it finishes the request.
    always_comb begin
        cur_q_s = 2'd0;
        last_s  = 1'b0;
        if (SKIP_EMPTY) begin
            // Pending quarters are exactly the non-zero bytes left in rem_mask.
            cur_q_s = lowest_quarter(rem_mask_q);
            last_s  = (clear_byte(rem_mask_q, cur_q_s) == 32'h0000_0000);
        end else begin
            // Every quarter is visited in order, empty or not.
            cur_q_s = cnt_q;
            last_s  = (cnt_q == 2'd3);
        end
    end

    // Next-state logic: request capture, per-grant progress, flush abort.
    always_comb begin
        state_d    = state_q;
        rem_mask_d = rem_mask_q;
        cnt_d      = cnt_q;
        trans_id_d = trans_id_q;

        if (flush_i) begin
            // Abort wins over everything; no completion is reported.
            state_d    = IDLE;
            rem_mask_d = 32'h0000_0000;
            cnt_d      = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        rem_mask_d = req_mask_i;
                        trans_id_d = req_trans_id_i;
                        cnt_d      = 2'd0;
                        // An all-zero mask has nothing to issue when empty
                        // quarters are skipped: complete straight away.
                        if (SKIP_EMPTY && (req_mask_i == 32'h0000_0000)) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end

                RUN: begin
                    if (clr_gnt_i) begin
                        if (SKIP_EMPTY) begin
                            rem_mask_d = clear_byte(rem_mask_q, cur_q_s);
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                        if (last_s) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        // Hold-until-grant: nothing moves.
                        state_d = RUN;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d    = IDLE;
                    rem_mask_d = 32'h0000_0000;
                    cnt_d      = 2'd0;
                end
            endcase
        end
    end

    // State registers; asynchronous reset abandons any request immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rem_mask_q <= 32'h0000_0000;
            cnt_q      <= 2'd0;
            trans_id_q <= {TRANS_ID_BITS{1'b0}};
        end else begin
            state_q    <= state_d;
            rem_mask_q <= rem_mask_d;
            cnt_q      <= cnt_d;
            trans_id_q <= trans_id_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign run_s = (state_q == RUN);

    assign req_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);

    assign clr_we_o        = run_s;
    assign clr_o           = run_s;
    assign clr_waddr_o     = 5'd0;
    assign clr_wdata_o     = 64'h0000_0000_0000_0000;
    // Quarter/mask are forced to zero outside RUN so that idle and DONE
    // present a quiet port regardless of what is left in rem_mask.
    assign clr_quarter_o   = run_s ? cur_q_s : 2'd0;
    assign clr_mask_o      = run_s ? mask_byte(rem_mask_q, cur_q_s) : 8'h00;

    assign done_valid_o    = (state_q == DONE);
    assign done_trans_id_o = trans_id_q;

endmodule

// File: tb/tb_cheri_clr_regs_seq.sv
// Testbench for cheri_clr_regs_seq. Two instances (SKIP_EMPTY=0 and =1)
// share one stimulus stream; each is compared every cycle against a
// queue-of-pending-quarters reference model, and each drives its own
// register-file model through the clear port.

module tb_cheri_clr_regs_seq;

    localparam int TID = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            flush;
    logic            valid;
    logic            gnt;
    logic [31:0]     req_mask;
    logic [TID-1:0]  req_id;

    logic [1:0]           ready_v, we_v, clr_v, done_v, busy_v;
    logic [1:0][7:0]      mask_v;
    logic [1:0][1:0]      q_v;
    logic [1:0][4:0]      waddr_v;
    logic [1:0][63:0]     wdata_v;
    logic [1:0][TID-1:0]  id_v;

    cheri_clr_regs_seq #(.TRANS_ID_BITS(TID), .SKIP_EMPTY(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(valid), .req_ready_o(ready_v[0]),
        .req_mask_i(req_mask), .req_trans_id_i(req_id),
        .clr_we_o(we_v[0]), .clr_o(clr_v[0]), .clr_waddr_o(waddr_v[0]),
        .clr_wdata_o(wdata_v[0]), .clr_mask_o(mask_v[0]),
        .clr_quarter_o(q_v[0]), .clr_gnt_i(gnt),
        .done_valid_o(done_v[0]), .done_trans_id_o(id_v[0]), .busy_o(busy_v[0])
    );

    cheri_clr_regs_seq #(.TRANS_ID_BITS(TID), .SKIP_EMPTY(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(valid), .req_ready_o(ready_v[1]),
        .req_mask_i(req_mask), .req_trans_id_i(req_id),
        .clr_we_o(we_v[1]), .clr_o(clr_v[1]), .clr_waddr_o(waddr_v[1]),
        .clr_wdata_o(wdata_v[1]), .clr_mask_o(mask_v[1]),
        .clr_quarter_o(q_v[1]), .clr_gnt_i(gnt),
        .done_valid_o(done_v[1]), .done_trans_id_o(id_v[1]), .busy_o(busy_v[1])
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    // Reference model, index k = SKIP_EMPTY value of the instance.
    bit             m_busy [2];
    bit             m_done [2];
    logic [1:0]     m_list [2][4];
    int             m_len  [2];
    int             m_head [2];
    logic [31:0]    m_mask [2];
    logic [TID-1:0] m_id   [2];

    logic [63:0]    rf      [2][32];
    logic [63:0]    rf_snap [2][32];
    int             wr_cnt  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_len[k]  = 0;
            m_head[k] = 0;
            m_mask[k] = 32'h0;
            m_id[k]   = '0;
        end
    endtask

    // One clock edge of the reference model for instance k.
    task automatic model_step(input int k);
        if (flush) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_len[k]  = 0;
            m_head[k] = 0;
        end else if (!m_busy[k]) begin
            if (valid) begin
                m_busy[k] = 1'b1;
                m_mask[k] = req_mask;
                m_id[k]   = req_id;
                m_len[k]  = 0;
                m_head[k] = 0;
                for (int q = 0; q < 4; q++) begin
                    if (k == 0 || ((req_mask >> (8 * q)) & 32'hFF) != 32'h0) begin
                        m_list[k][m_len[k]] = 2'(q);
                        m_len[k]++;
                    end
                end
                m_done[k] = (m_len[k] == 0);
            end
        end else if (m_done[k]) begin
            m_done[k] = 1'b0;
            m_busy[k] = 1'b0;
        end else if (gnt) begin
            m_head[k]++;
            if (m_head[k] == m_len[k]) m_done[k] = 1'b1;
        end
    endtask

    // Register-file models take whatever each DUT writes when granted.
    task automatic apply_writes();
        for (int k = 0; k < 2; k++) begin
            if (we_v[k] === 1'b1 && gnt === 1'b1) begin
                wr_cnt[k]++;
                for (int b = 0; b < 8; b++) begin
                    if (mask_v[k][b]) rf[k][int'(q_v[k]) * 8 + b] = 64'h0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic       exp_we;
        logic [1:0] exp_q;
        for (int k = 0; k < 2; k++) begin
            exp_we = m_busy[k] && !m_done[k];
            chk($sformatf("%s_d%0d_ready", tag, k), 64'(ready_v[k]), 64'(!m_busy[k]));
            chk($sformatf("%s_d%0d_busy",  tag, k), 64'(busy_v[k]),  64'(m_busy[k]));
            chk($sformatf("%s_d%0d_we",    tag, k), 64'(we_v[k]),    64'(exp_we));
            chk($sformatf("%s_d%0d_clr",   tag, k), 64'(clr_v[k]),   64'(exp_we));
            chk($sformatf("%s_d%0d_done",  tag, k), 64'(done_v[k]),  64'(m_done[k]));
            chk($sformatf("%s_d%0d_waddr", tag, k), 64'(waddr_v[k]), 64'h0);
            chk($sformatf("%s_d%0d_wdata", tag, k), wdata_v[k],      64'h0);
            if (exp_we) begin
                exp_q = m_list[k][m_head[k]];
                chk($sformatf("%s_d%0d_quarter", tag, k), 64'(q_v[k]), 64'(exp_q));
                chk($sformatf("%s_d%0d_mask", tag, k), 64'(mask_v[k]),
                    64'((m_mask[k] >> (8 * int'(exp_q))) & 32'hFF));
            end
            if (m_done[k]) begin
                chk($sformatf("%s_d%0d_id", tag, k), 64'(id_v[k]), 64'(m_id[k]));
            end
        end
    endtask

    // Advance one clock: update models with the inputs set for this edge,
    // then check outputs on the following falling edge.
    task automatic cycle();
        apply_writes();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [31:0] m, input logic [TID-1:0] id);
        req_mask = m;
        req_id   = id;
        valid    = 1'b1;
        cycle();
        valid    = 1'b0;
    endtask

    task automatic clear_wr();
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
    endtask

    task automatic seed_rf();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                rf[k][r]      = {$urandom, $urandom} | 64'h1;
                rf_snap[k][r] = rf[k][r];
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_d%0d_ready", tag, k), 64'(ready_v[k]), 64'h1);
            chk($sformatf("%s_d%0d_we",    tag, k), 64'(we_v[k]),    64'h0);
            chk($sformatf("%s_d%0d_clr",   tag, k), 64'(clr_v[k]),   64'h0);
            chk($sformatf("%s_d%0d_mask",  tag, k), 64'(mask_v[k]),  64'h0);
            chk($sformatf("%s_d%0d_qtr",   tag, k), 64'(q_v[k]),     64'h0);
            chk($sformatf("%s_d%0d_done",  tag, k), 64'(done_v[k]),  64'h0);
            chk($sformatf("%s_d%0d_id",    tag, k), 64'(id_v[k]),    64'h0);
            chk($sformatf("%s_d%0d_busy",  tag, k), 64'(busy_v[k]),  64'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int changed;
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid    = 1'b0;
        gnt      = 1'b0;
        req_mask = 32'h0;
        req_id   = '0;
        model_reset();
        seed_rf();
        clear_wr();

        // Reset state
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("idle");

        // Single-quarter request, grant tied high
        gnt = 1'b1;
        clear_wr();
        send(32'h0000_00F0, 3'd5);
        chk("t1_c1_we",  64'(we_v[1]),   64'h1);
        chk("t1_c1_qtr", 64'(q_v[1]),    64'h0);
        chk("t1_c1_msk", 64'(mask_v[1]), 64'hF0);
        cycle();
        chk("t1_c2_done", 64'(done_v[1]), 64'h1);
        chk("t1_c2_id",   64'(id_v[1]),   64'h5);
        run(4);
        chk("t1_wr_d1", 64'(wr_cnt[1]), 64'd1);
        chk("t1_wr_d0", 64'(wr_cnt[0]), 64'd4);

        // Hold-until-grant: grant low in cycles 1-2
        gnt = 1'b0;
        clear_wr();
        send(32'hFF00_0001, 3'd1);
        cycle();
        cycle();
        chk("t2_c3_qtr", 64'(q_v[1]),    64'h0);
        chk("t2_c3_msk", 64'(mask_v[1]), 64'h01);
        gnt = 1'b1;
        cycle();
        chk("t2_c4_qtr", 64'(q_v[1]),    64'h3);
        chk("t2_c4_msk", 64'(mask_v[1]), 64'hFF);
        cycle();
        chk("t2_c5_done", 64'(done_v[1]), 64'h1);
        run(4);
        chk("t2_wr_d1", 64'(wr_cnt[1]), 64'd2);
        chk("t2_wr_d0", 64'(wr_cnt[0]), 64'd4);

        // Zero mask
        clear_wr();
        send(32'h0000_0000, 3'd2);
        chk("t3_c1_done_d1", 64'(done_v[1]), 64'h1);
        chk("t3_c1_we_d1",   64'(we_v[1]),   64'h0);
        run(4);
        chk("t3_c5_done_d0", 64'(done_v[0]), 64'h1);
        cycle();
        chk("t3_wr_d1", 64'(wr_cnt[1]), 64'd0);
        chk("t3_wr_d0", 64'(wr_cnt[0]), 64'd4);

        // Flush in cycle 2 of a full-mask request
        clear_wr();
        send(32'hFFFF_FFFF, 3'd3);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t4_c3_ready_d1", 64'(ready_v[1]), 64'h1);
        chk("t4_c3_ready_d0", 64'(ready_v[0]), 64'h1);
        chk("t4_c3_done_d1",  64'(done_v[1]),  64'h0);
        run(2);
        chk("t4_wr_d1", 64'(wr_cnt[1]), 64'd2);
        chk("t4_wr_d0", 64'(wr_cnt[0]), 64'd2);

        // Asynchronous reset during RUN
        gnt = 1'b0;
        send(32'hFFFF_FFFF, 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        gnt   = 1'b1;
        clear_wr();
        send(32'h0001_0000, 3'd6);
        chk("t5_c1_qtr", 64'(q_v[1]),    64'h2);
        chk("t5_c1_msk", 64'(mask_v[1]), 64'h01);
        cycle();
        chk("t5_c2_done", 64'(done_v[1]), 64'h1);
        chk("t5_c2_id",   64'(id_v[1]),   64'h6);
        run(4);

        // Register-file scoreboard
        seed_rf();
        send(32'h8000_8000, 3'd7);
        run(6);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t6_d%0d_x15", k), rf[k][15], 64'h0);
            chk($sformatf("t6_d%0d_x31", k), rf[k][31], 64'h0);
            changed = 0;
            for (int r = 0; r < 32; r++) begin
                if (r != 15 && r != 31 && rf[k][r] !== rf_snap[k][r]) changed++;
            end
            chk($sformatf("t6_d%0d_others", k), 64'(changed), 64'h0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 1) == 1);
            for (int b = 0; b < 4; b++) begin
                req_mask[b*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            end
            req_id = TID'($urandom);
            gnt    = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 31) == 0);
            cycle();
        end
        valid = 1'b0;
        flush = 1'b0;
        gnt   = 1'b1;
        run(8);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
